// File: rtl/avionics_pkg.sv
// Shared avionics constants: system clock and frame rate, sequencer state encoding.
package avionics_pkg;

  localparam int SYS_CLK_HZ         = 1_000_000;
  localparam int FRAME_RATE_HZ      = 10;
  localparam int DEF_FRAME_CYCLES   = SYS_CLK_HZ / FRAME_RATE_HZ;
  localparam int DEF_NUM_SLOTS      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 20000;
  localparam int DEF_CNT_W          = 17;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_SCAN  = 2'd1;
  localparam seq_state_t ST_ISSUE = 2'd2;
  localparam seq_state_t ST_WAIT  = 2'd3;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame timebase: counts 1..FRAME_CYCLES and emits a registered one-cycle tick
// as the count wraps. Disabling holds the count at 1 so re-enable gives a full period.
module frame_tick_gen
  import avionics_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_b,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= CNT_FIRST;
      tick  <= 1'b0;
    end else if (!enable) begin
      count <= CNT_FIRST;
      tick  <= 1'b0;
    end else if (count == CNT_LAST) begin
      count <= CNT_FIRST;
      tick  <= 1'b1;
    end else begin
      count <= count + CNT_FIRST;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sampling scheduler: on each frame tick, starts each enabled requester
// in fixed priority order and waits for its done or a timeout before moving on.
//
// state | meaning
// IDLE  | waiting for a frame tick
// SCAN  | looking for the next enabled slot (one cycle per slot)
// ISSUE | start pulse to the current slot, timer cleared
// WAIT  | waiting for done from the current slot or timeout
module frame_sequencer
  import avionics_pkg::*;
#(
  parameter int FRAME_CYCLES   = DEF_FRAME_CYCLES,
  parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                 CLK_1MHZ_IN,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [NUM_SLOTS-1:0] SLOT_MASK,
  input  logic [NUM_SLOTS-1:0] SLOT_DONE,
  output logic [NUM_SLOTS-1:0] SLOT_START,
  output logic                 FRAME_TICK,
  output logic                 BUSY,
  output logic [NUM_SLOTS-1:0] TIMEOUT_FLAGS,
  output logic                 OVERRUN,
  output logic [15:0]          FRAME_COUNT
);

  localparam int IDX_W = $clog2(NUM_SLOTS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_SLOTS);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  seq_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic [TMR_W-1:0]     timer;
  logic [NUM_SLOTS-1:0] mask_q;
  logic [NUM_SLOTS-1:0] start_q;
  logic [NUM_SLOTS-1:0] flags_q;
  logic [NUM_SLOTS-1:0] idx_onehot;
  logic [15:0]          frame_count_q;
  logic                 busy_q;
  logic                 overrun_q;
  logic                 frame_tick;
  logic                 mask_hit;
  logic                 done_hit;

  frame_tick_gen #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_tick_gen (
    .clk    (CLK_1MHZ_IN),
    .rst_b  (RESET),
    .enable (ENABLE),
    .tick   (frame_tick)
  );

  // Current-slot selects; idx == NUM_SLOTS matches nothing, so SCAN exits cleanly.
  always_comb begin
    mask_hit   = 1'b0;
    done_hit   = 1'b0;
    idx_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == IDX_W'(i)) begin
        mask_hit      = mask_q[i];
        done_hit      = SLOT_DONE[i];
        idx_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      state         <= ST_IDLE;
      idx           <= '0;
      timer         <= '0;
      mask_q        <= '0;
      start_q       <= '0;
      flags_q       <= '0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      start_q <= '0;

      if (frame_tick) begin
        frame_count_q <= frame_count_q + 16'd1;
        if (state != ST_IDLE) overrun_q <= 1'b1;
      end

      if (!ENABLE) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (frame_tick) begin
              mask_q  <= SLOT_MASK;
              flags_q <= '0;
              idx     <= '0;
              state   <= ST_SCAN;
              busy_q  <= 1'b1;
            end
          end
          ST_SCAN: begin
            if (idx == IDX_END) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else if (mask_hit) begin
              // Registered here so the pulse lines up exactly with the ISSUE cycle.
              start_q <= idx_onehot;
              state   <= ST_ISSUE;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
          ST_ISSUE: begin
            timer <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (done_hit) begin
              idx   <= idx + IDX_ONE;
              state <= ST_SCAN;
            end else if (timer == TMR_LAST) begin
              flags_q <= flags_q | idx_onehot;
              idx     <= idx + IDX_ONE;
              state   <= ST_SCAN;
            end else begin
              timer <= timer + TMR_ONE;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SLOT_START    = start_q;
  assign FRAME_TICK    = frame_tick;
  assign BUSY          = busy_q;
  assign TIMEOUT_FLAGS = flags_q;
  assign OVERRUN       = overrun_q;
  assign FRAME_COUNT   = frame_count_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer: two instances (50- and 20-cycle frames)
// checked every cycle against an event-time model of each frame's schedule.
module tb_frame_sequencer;

  localparam int EN_FR  = 6;
  localparam int RST_FR = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       en       [2];
  logic [3:0] mask_in  [2];
  logic [3:0] done_in  [2];
  logic [3:0] start_o  [2];
  logic [3:0] flags_o  [2];
  logic       tick_o   [2];
  logic       busy_o   [2];
  logic       ovr_o    [2];
  logic [15:0] count_o [2];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // model state: absolute cycle numbers of every expected event
  int         next_tick [2];
  int         busy_from [2];
  int         busy_to   [2];
  int         cnt_inc   [2];
  int         clr_at    [2];
  int         ovr_at    [2];
  int         frame_no  [2];
  int         st_t      [2][4];
  int         fl_t      [2][4];
  int         dly       [2][4];
  logic [3:0] m_mask    [2];
  logic [3:0] e_flags   [2];
  logic [15:0] e_count  [2];
  logic       e_ovr     [2];
  logic       en_prev   [2];
  int drop_at  = -1;
  int raise_at = -1;
  int rst_at   = -1;
  int end_at   = -1;

  frame_sequencer #(
    .FRAME_CYCLES(50), .NUM_SLOTS(4), .TIMEOUT_CYCLES(8), .CNT_W(17)
  ) dut0 (
    .CLK_1MHZ_IN(clk), .RESET(reset), .ENABLE(en[0]),
    .SLOT_MASK(mask_in[0]), .SLOT_DONE(done_in[0]), .SLOT_START(start_o[0]),
    .FRAME_TICK(tick_o[0]), .BUSY(busy_o[0]), .TIMEOUT_FLAGS(flags_o[0]),
    .OVERRUN(ovr_o[0]), .FRAME_COUNT(count_o[0])
  );

  frame_sequencer #(
    .FRAME_CYCLES(20), .NUM_SLOTS(4), .TIMEOUT_CYCLES(8), .CNT_W(17)
  ) dut1 (
    .CLK_1MHZ_IN(clk), .RESET(reset), .ENABLE(en[1]),
    .SLOT_MASK(mask_in[1]), .SLOT_DONE(done_in[1]), .SLOT_START(start_o[1]),
    .FRAME_TICK(tick_o[1]), .BUSY(busy_o[1]), .TIMEOUT_FLAGS(flags_o[1]),
    .OVERRUN(ovr_o[1]), .FRAME_COUNT(count_o[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fc(input int k);
    return (k == 0) ? 50 : 20;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int k);
    check($sformatf("rst_start%0d", k), start_o[k], 0);
    check($sformatf("rst_tick%0d", k), tick_o[k], 0);
    check($sformatf("rst_busy%0d", k), busy_o[k], 0);
    check($sformatf("rst_flags%0d", k), flags_o[k], 0);
    check($sformatf("rst_ovr%0d", k), ovr_o[k], 0);
    check($sformatf("rst_count%0d", k), count_o[k], 0);
  endtask

  task automatic model_reset(input int k, input int c0);
    next_tick[k] = c0 + fc(k);
    busy_from[k] = -100;
    busy_to[k]   = -100;
    cnt_inc[k]   = -1;
    clr_at[k]    = -1;
    ovr_at[k]    = -1;
    for (int i = 0; i < 4; i++) begin
      st_t[k][i] = -100;
      fl_t[k][i] = -100;
      dly[k][i]  = 0;
    end
    m_mask[k]  = '0;
    e_flags[k] = '0;
    e_count[k] = '0;
    e_ovr[k]   = 1'b0;
    en_prev[k] = 1'b1;
  endtask

  // Lay out one serviced frame: SCAN costs 1 cycle per slot, a started slot
  // costs ISSUE + up to 8 WAIT cycles, done on WAIT cycle d ends it early.
  task automatic start_frame(input int k, input int c);
    logic [3:0] m;
    int t;
    frame_no[k]++;
    m = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) dly[k][i] = $urandom_range(0, 12);
    if (k == 0 && frame_no[k] == 1) begin
      m = 4'b1111;
      for (int i = 0; i < 4; i++) dly[k][i] = 3;
    end else if (k == 0 && frame_no[k] == 2) begin
      m = 4'b0101; dly[k][0] = 3; dly[k][2] = 12;
    end else if (k == 0 && frame_no[k] == 3) begin
      m = 4'b1111; dly[k][0] = 8; dly[k][1] = 0; dly[k][2] = 5; dly[k][3] = 8;
    end else if (k == 0 && (frame_no[k] == EN_FR || frame_no[k] == RST_FR)) begin
      m = 4'b0001; dly[k][0] = 12;
    end else if (k == 1 && frame_no[k] == 1) begin
      m = 4'b1111;
      for (int i = 0; i < 4; i++) dly[k][i] = 12;
    end
    if (k == 0 && frame_no[k] == EN_FR) begin
      drop_at  = c + 6;
      raise_at = c + 13;
    end
    if (k == 0 && frame_no[k] == RST_FR) rst_at = c + 2;
    mask_in[k]   = m;
    m_mask[k]    = m;
    clr_at[k]    = c + 1;
    busy_from[k] = c + 1;
    t = c + 1;
    for (int i = 0; i < 4; i++) begin
      st_t[k][i] = -100;
      fl_t[k][i] = -100;
      if (m[i]) begin
        st_t[k][i] = t + 1;
        if (dly[k][i] >= 1 && dly[k][i] <= 8) begin
          t = st_t[k][i] + dly[k][i] + 1;
        end else begin
          fl_t[k][i] = st_t[k][i] + 9;
          t = st_t[k][i] + 9;
        end
      end else begin
        t = t + 1;
      end
    end
    busy_to[k] = t;
  endtask

  task automatic step(input int k);
    int c;
    logic [3:0] exp_start;
    logic exp_busy, exp_tick;
    c = cyc;
    if (c == cnt_inc[k]) e_count[k] = e_count[k] + 16'd1;
    if (c == clr_at[k]) e_flags[k] = '0;
    if (c == ovr_at[k]) e_ovr[k] = 1'b1;
    exp_start = '0;
    for (int i = 0; i < 4; i++) begin
      if (fl_t[k][i] == c) e_flags[k][i] = 1'b1;
      if (st_t[k][i] == c) exp_start[i] = 1'b1;
    end
    exp_busy = (c >= busy_from[k]) && (c <= busy_to[k]);
    exp_tick = (c == next_tick[k]);

    check($sformatf("tick%0d@%0d", k, c), tick_o[k], exp_tick);
    check($sformatf("start%0d@%0d", k, c), start_o[k], exp_start);
    check($sformatf("busy%0d@%0d", k, c), busy_o[k], exp_busy);
    check($sformatf("flags%0d@%0d", k, c), flags_o[k], e_flags[k]);
    check($sformatf("ovr%0d@%0d", k, c), ovr_o[k], e_ovr[k]);
    check($sformatf("count%0d@%0d", k, c), count_o[k], e_count[k]);

    en[k] = !(k == 0 && c >= drop_at && c < raise_at);
    if (exp_tick) begin
      cnt_inc[k] = c + 1;
      if (c <= busy_to[k]) ovr_at[k] = c + 1;
      else if (en[k]) start_frame(k, c);
      next_tick[k] = c + fc(k);
    end
    if (!en[k]) begin
      next_tick[k] = -1;
      for (int i = 0; i < 4; i++) begin
        if (st_t[k][i] > c) st_t[k][i] = -100;
        if (fl_t[k][i] > c) fl_t[k][i] = -100;
      end
      if (busy_to[k] > c) busy_to[k] = c;
    end else if (!en_prev[k]) begin
      next_tick[k] = c + fc(k);
    end
    en_prev[k] = en[k];

    for (int i = 0; i < 4; i++) begin
      if (m_mask[k][i]) done_in[k][i] = (st_t[k][i] >= 0) && (c == st_t[k][i] + dly[k][i]);
      else              done_in[k][i] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; mask_in[k] = '0; done_in[k] = '0; frame_no[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) check_zero(k);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b1;
      model_reset(k, cyc);
    end

    forever begin
      @(negedge clk);
      if (cyc > 4000) begin
        check("cycle_budget", cyc, 4000);
        break;
      end
      for (int k = 0; k < 2; k++) step(k);
      if (end_at >= 0 && cyc >= end_at) break;
      if (rst_at >= 0 && cyc + 1 == rst_at) begin
        @(posedge clk);
        #2;
        check("start_pre_rst", start_o[0], 4'b0001);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check_zero(k);
        repeat (3) begin
          @(negedge clk);
          for (int k = 0; k < 2; k++) check_zero(k);
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k, cyc);
        rst_at = -1;
        end_at = cyc + 130;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame sampling scheduler for the avionics board, clocked from the 1 MHz system clock.
- Generates a 10 Hz frame tick internally.
- On each tick, shares the frame time between up to NUM_SLOTS sensor/telemetry requesters. Each enabled requester gets a one-cycle start pulse in fixed priority order, and the block waits for its done response or a timeout before moving on.
- Reports per-slot timeouts, frame overruns and a frame counter to the telemetry packer.

Parameters:
- FRAME_CYCLES, 100000, clock cycles per frame (10 Hz at 1 MHz).
- NUM_SLOTS, 4, number of requesters sequenced per frame.
- TIMEOUT_CYCLES, 20000, maximum WAIT cycles per slot before it is abandoned.
- CNT_W, 17, frame counter width; must satisfy 2^CNT_W > FRAME_CYCLES.

Ports:
- CLK_1MHZ_IN  input  1  system clock, 1 MHz.
- RESET  input  1  asynchronous, active-low reset.
- ENABLE  input  1  1 = frames run; 0 = counter held and sequence aborted.
- SLOT_MASK  input  NUM_SLOTS  bit i = 1 includes slot i in the frame; latched at the frame tick.
- SLOT_DONE  input  NUM_SLOTS  completion pulse or level from requester i.
- SLOT_START  output  NUM_SLOTS  one-cycle start pulse to requester i.
- FRAME_TICK  output  1  one-cycle pulse once per frame.
- BUSY  output  1  high while a frame sequence is in progress.
- TIMEOUT_FLAGS  output  NUM_SLOTS  bit i set if slot i timed out in the current or most recent frame.
- OVERRUN  output  1  sticky; frame tick arrived while the sequence was still busy.
- FRAME_COUNT  output  16  number of frame ticks since reset; wraps 65535 -> 0.

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0; frame counter = 1; state = IDLE; slot index = 0; latched mask = 0.
- Frame counter, while ENABLE=1:
  - Increments by 1 each cycle.
  - When counter == FRAME_CYCLES: FRAME_TICK = 1 for that cycle, and the counter returns to 1.
  - Period is exactly FRAME_CYCLES cycles. FRAME_TICK is registered.
- ENABLE=0: counter forced to 1; FSM goes to IDLE on the next edge; SLOT_START = 0. TIMEOUT_FLAGS and FRAME_COUNT hold.
- Every FRAME_TICK increments FRAME_COUNT, whether or not the frame is serviced.
- FSM states: IDLE, SCAN, ISSUE, WAIT.
- IDLE, when FRAME_TICK=1: latch SLOT_MASK, clear TIMEOUT_FLAGS, set index = 0, go to SCAN.
- SCAN:
  - index == NUM_SLOTS -> IDLE.
  - Latched mask[index] = 1 -> ISSUE.
  - Otherwise index + 1 and stay in SCAN (one cycle per skipped slot).
- ISSUE: SLOT_START[index] = 1 for exactly this cycle; timeout timer cleared to 0; go to WAIT.
- WAIT:
  - SLOT_DONE[index] = 1 -> index + 1, go to SCAN.
  - Else if timer == TIMEOUT_CYCLES-1 -> set TIMEOUT_FLAGS[index], index + 1, go to SCAN.
  - Else timer + 1.
  - DONE takes priority over timeout in the same cycle.
- Latency: FRAME_TICK in cycle T with mask bit 0 set -> SLOT_START[0] in cycle T+2. DONE is first sampled in cycle T+3.
- SLOT_DONE is ignored outside WAIT, and for slots other than the current index.
- BUSY = (state != IDLE), registered with the state.
- OVERRUN:
  - FRAME_TICK while state != IDLE sets OVERRUN.
  - The current sequence continues undisturbed, and the new frame is not serviced.
  - OVERRUN is cleared only by reset.
- A mask of all zeros: SCAN walks to NUM_SLOTS and returns to IDLE, with no starts. BUSY is high for NUM_SLOTS+1 cycles.
- Reset mid-WAIT: immediate return to the reset values; any partially driven start is dropped.
- At most one SLOT_START bit is high in any cycle.

Decomposition:
- Shared package (avionics_pkg): FSM state encoding localparams (IDLE=0, SCAN=1, ISSUE=2, WAIT=3) and the 1 MHz/10 Hz frame constants.
- Sub-module frame_tick_gen: counter 1..FRAME_CYCLES, producing FRAME_TICK, with ENABLE and RESET.
- Sequencing FSM, timer, flags and FRAME_COUNT remain in frame_sequencer.

Test Plan:
- Bench parameters for all scenarios: FRAME_CYCLES=50, TIMEOUT_CYCLES=8, NUM_SLOTS=4.
- Scenario 1: reset release, ENABLE=1, mask=4'b1111, each DONE returned 3 cycles after its START -> FRAME_TICK every 50 cycles; START[0..3] in order, first at tick+2; TIMEOUT_FLAGS=0; FRAME_COUNT=1 after the first tick.
- Scenario 2: mask=4'b0101, slot 2 never responds -> START[0] and START[2] only; START[2] followed by exactly 8 WAIT cycles, then TIMEOUT_FLAGS=4'b0100, BUSY falls; flags clear at the next tick.
- Scenario 3: all slots never respond (4x(1+8) cycles plus SCAN cycles < 50), then FRAME_CYCLES=20 rerun -> OVERRUN=1 at the first tick seen while BUSY; that frame is not serviced; FRAME_COUNT still increments.
- Scenario 4: DONE and timeout expiry in the same cycle -> no timeout flag set. DONE asserted during ISSUE or for a wrong slot -> ignored.
- Scenario 5: ENABLE dropped mid-WAIT -> state IDLE next cycle, no further START. ENABLE re-raised -> first tick exactly 50 cycles later.
- Scenario 6: RESET asserted mid-frame, asynchronously between edges -> all outputs 0 immediately; the counter restarts at 1 after release.
